// File: rtl/ioctl_upload_server_pkg.sv
// ============================================================================
//  Module      : ioctl_upload_server_pkg
//  Description : Shared types and constants for the HPS save-RAM upload server
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ioctl_upload_server_pkg;

  // Byte-service FSM: wait for a strobe, hold a RAM request, capture RAM data
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } upl_state_t;

  // Byte returned for addresses beyond the exposed save RAM
  localparam logic [7:0] c_fill_byte = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/ioctl_upload_server.sv
// ============================================================================
//  Module      : ioctl_upload_server
//  Description : Serves HPS ioctl upload reads from the save RAM through an
//                arbitrated read port, with a one-entry pending strobe,
//                upload request handshake, CPU pause and byte counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ioctl_upload_server
  import ioctl_upload_server_pkg::*;
#(
  parameter int         SIZE         = 1024,
  parameter int         ADDR_W       = 10,
  parameter logic [7:0] UPLOAD_INDEX = 8'd4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              save_req,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_upload_req,
  output logic              pause_cpu,
  output logic              ram_req,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_gnt,
  input  logic [7:0]        ram_q,
  output logic              busy,
  output logic [ADDR_W:0]   byte_count
);

  localparam logic [24:0]   c_size      = 25'(SIZE);
  localparam logic [ADDR_W:0] c_count_max = (ADDR_W+1)'(SIZE);
  localparam logic [ADDR_W:0] c_count_one = (ADDR_W+1)'(1);

  upl_state_t        r_state;
  upl_state_t        w_state_nxt;
  logic              r_session_q;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_din;
  logic              r_upload_req;
  logic              r_pause;
  logic [ADDR_W:0]   r_count;
  logic              r_pend_vld;
  logic [24:0]       r_pend_addr;

  logic              w_session;
  logic              w_rise;
  logic              w_rd_ok;
  logic              w_pend_ok;
  logic [24:0]       w_src_addr;
  logic              w_src_in_range;
  logic              w_cap;
  logic              w_load;
  logic [7:0]        w_din_nxt;
  logic              w_pend_set;
  logic              w_pend_clr;

  assign w_session      = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign w_rise         = w_session && !r_session_q;
  assign w_rd_ok        = ioctl_rd && w_session;
  // A pending strobe is only honoured while the session is still live
  assign w_pend_ok      = r_pend_vld && w_session;
  assign w_src_addr     = w_pend_ok ? r_pend_addr : ioctl_addr;
  assign w_src_in_range = (w_src_addr < c_size);

  // State register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, byte load and pending-entry control
  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_load      = 1'b0;
    w_din_nxt   = r_din;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pend_ok || w_rd_ok) begin
          w_pend_clr = w_pend_ok;
          // Pending is older, so a coincident fresh strobe takes its place
          w_pend_set = w_pend_ok && w_rd_ok;
          if (w_src_in_range) begin
            w_state_nxt = ST_REQ;
            w_cap       = 1'b1;
          end else begin
            w_load    = 1'b1;
            w_din_nxt = c_fill_byte;
          end
        end
      end
      ST_REQ: begin
        if (ram_gnt) w_state_nxt = ST_DATA;
        w_pend_set = w_rd_ok;
      end
      ST_DATA: begin
        w_state_nxt = ST_IDLE;
        w_load      = 1'b1;
        w_din_nxt   = ram_q;
        w_pend_set  = w_rd_ok;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers: address capture, returned byte, pending entry
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_din       <= 8'h00;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
    end else begin
      if (w_cap)  r_addr <= w_src_addr[ADDR_W-1:0];
      if (w_load) r_din  <= w_din_nxt;
      if (!w_session) begin
        r_pend_vld <= 1'b0;
      end else if (w_pend_set) begin
        r_pend_vld  <= 1'b1;
        r_pend_addr <= ioctl_addr;
      end else if (w_pend_clr) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  // Session edge, upload handshake, CPU pause and served-byte counter
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_session_q  <= 1'b0;
      r_upload_req <= 1'b0;
      r_pause      <= 1'b0;
      r_count      <= '0;
    end else begin
      r_session_q <= w_session;
      if (w_rise)                      r_upload_req <= 1'b0;
      else if (save_req && !w_session) r_upload_req <= 1'b1;
      if (w_session)                                  r_pause <= 1'b1;
      else if ((r_state == ST_IDLE) && !w_pend_ok)    r_pause <= 1'b0;
      if (w_rise)                                     r_count <= '0;
      else if (w_load && (r_count != c_count_max))    r_count <= r_count + c_count_one;
    end
  end

  assign ioctl_din        = r_din;
  assign ioctl_upload_req = r_upload_req;
  assign pause_cpu        = r_pause;
  assign ram_req          = (r_state == ST_REQ);
  assign ram_addr         = r_addr;
  assign busy             = (r_state != ST_IDLE);
  assign byte_count       = r_count;

endmodule

`default_nettype wire

// File: tb/tb_ioctl_upload_server.sv
// ============================================================================
//  Module      : tb_ioctl_upload_server
//  Description : Self-checking bench for ioctl_upload_server
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ioctl_upload_server;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        save_req;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_upload_req;
  logic        pause_cpu;
  logic        ram_req;
  logic [9:0]  ram_addr;
  logic        ram_gnt;
  logic [7:0]  ram_q;
  logic        busy;
  logic [10:0] byte_count;

  ioctl_upload_server #(.SIZE(1024), .ADDR_W(10), .UPLOAD_INDEX(8'd4)) dut (
    .clk_sys(clk_sys), .reset(reset), .save_req(save_req),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
    .ioctl_upload_req(ioctl_upload_req), .pause_cpu(pause_cpu),
    .ram_req(ram_req), .ram_addr(ram_addr), .ram_gnt(ram_gnt),
    .ram_q(ram_q), .busy(busy), .byte_count(byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  // Save RAM model: data valid exactly one cycle after the grant cycle
  logic [7:0] mem [0:1023];
  always @(posedge clk_sys)
    ram_q <= (ram_req && ram_gnt) ? mem[ram_addr] : 8'h5A;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic issue_rd(input logic [24:0] a, input bit push, input logic [7:0] e);
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    if (push) sb.push_back(e);
    tick();
    ioctl_rd = 1'b0;
  endtask

  task automatic restart_session();
    ioctl_upload = 1'b0;
    tick(); tick();
    ioctl_upload = 1'b1;
    tick();
  endtask

  // Scoreboard: each counted byte load pops the oldest expected byte
  int prev_cnt = 0;
  always @(negedge clk_sys) begin
    if (reset) prev_cnt = 0;
    else begin
      if (int'(byte_count) == prev_cnt + 1) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_unexpected: ioctl_din=%0h with no expected byte", ioctl_din);
        end else begin
          check("sb_din", {24'h0, ioctl_din}, {24'h0, sb.pop_front()});
        end
      end
      prev_cnt = int'(byte_count);
    end
  end

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  din;
    bit          uses_ram;
  } vec_t;
  vec_t vt [7];

  initial begin
    logic [7:0]  prev;
    logic [10:0] cnt0;
    int          waited;

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[5] = 8'hA5;

    vt[0] = '{25'd5,         8'hA5, 1'b1};
    vt[1] = '{25'd1024,      8'hFF, 1'b0};
    vt[2] = '{25'd0,         8'h3C, 1'b1};
    vt[3] = '{25'd1023,      8'hC3, 1'b1};
    vt[4] = '{25'h1FFFFFF,   8'hFF, 1'b0};
    vt[5] = '{25'd1,         8'h3D, 1'b1};
    vt[6] = '{25'd2000,      8'hFF, 1'b0};

    reset = 1'b1; save_req = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd4;
    ioctl_rd = 1'b0; ioctl_addr = '0; ram_gnt = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset values
    check("rst_din",  {24'h0, ioctl_din}, 32'h0);
    check("rst_ureq", {31'h0, ioctl_upload_req}, 32'h0);
    check("rst_pause",{31'h0, pause_cpu}, 32'h0);
    check("rst_rreq", {31'h0, ram_req}, 32'h0);
    check("rst_raddr",{22'h0, ram_addr}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_cnt",  {21'h0, byte_count}, 32'h0);

    // Save request handshake and session start
    save_req = 1'b1; tick(); save_req = 1'b0;
    check("ureq_set", {31'h0, ioctl_upload_req}, 32'h1);
    tick();
    check("ureq_hold", {31'h0, ioctl_upload_req}, 32'h1);
    ioctl_upload = 1'b1;
    check("pause_pre", {31'h0, pause_cpu}, 32'h0);
    tick();
    check("ureq_clr", {31'h0, ioctl_upload_req}, 32'h0);
    check("pause_on", {31'h0, pause_cpu}, 32'h1);
    save_req = 1'b1; tick(); save_req = 1'b0; tick();
    check("ureq_in_sess", {31'h0, ioctl_upload_req}, 32'h0);

    // Table: single reads with grant already high
    for (int i = 0; i < 7; i++) begin
      prev = ioctl_din;
      cnt0 = byte_count;
      issue_rd(vt[i].addr, 1'b1, vt[i].din);
      if (vt[i].uses_ram) begin
        check($sformatf("v%0d_rreq", i), {31'h0, ram_req}, 32'h1);
        check($sformatf("v%0d_raddr", i), {22'h0, ram_addr}, {22'h0, vt[i].addr[9:0]});
        check($sformatf("v%0d_hold", i), {24'h0, ioctl_din}, {24'h0, prev});
        tick(); tick();
        check($sformatf("v%0d_din", i), {24'h0, ioctl_din}, {24'h0, vt[i].din});
      end else begin
        check($sformatf("v%0d_din", i), {24'h0, ioctl_din}, {24'h0, vt[i].din});
        check($sformatf("v%0d_norreq", i), {31'h0, ram_req}, 32'h0);
        tick();
        check($sformatf("v%0d_norreq2", i), {31'h0, ram_req}, 32'h0);
      end
      check($sformatf("v%0d_cnt", i), {21'h0, byte_count}, {21'h0, cnt0 + 11'd1});
      tick();
    end

    // Grant withheld with a second strobe queued behind the first
    restart_session();
    check("wait_cnt0", {21'h0, byte_count}, 32'h0);
    ram_gnt = 1'b0;
    issue_rd(25'd10, 1'b1, mem[10]);
    tick();
    issue_rd(25'd7, 1'b1, mem[7]);
    for (int i = 0; i < 7; i++) tick();
    check("wait_rreq", {31'h0, ram_req}, 32'h1);
    check("wait_raddr", {22'h0, ram_addr}, 32'd10);
    check("wait_busy", {31'h0, busy}, 32'h1);
    check("wait_cnt", {21'h0, byte_count}, 32'h0);
    ram_gnt = 1'b1;
    waited = 0;
    while (byte_count != 11'd2 && waited < 30) begin tick(); waited++; end
    check("wait_cnt2", {21'h0, byte_count}, 32'd2);
    check("wait_din", {24'h0, ioctl_din}, {24'h0, mem[7]});
    tick();
    check("wait_idle", {31'h0, busy}, 32'h0);

    // pause_cpu falls one cycle after an idle session ends
    ioctl_upload = 1'b0;
    check("pause_hold", {31'h0, pause_cpu}, 32'h1);
    tick();
    check("pause_off", {31'h0, pause_cpu}, 32'h0);

    // Session ends mid-access: access completes, pending discarded
    ioctl_upload = 1'b1; tick();
    ram_gnt = 1'b0;
    issue_rd(25'd20, 1'b1, mem[20]);
    issue_rd(25'd21, 1'b0, 8'h00);
    ioctl_upload = 1'b0;
    tick();
    check("end_pause", {31'h0, pause_cpu}, 32'h1);
    ram_gnt = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("end_cnt", {21'h0, byte_count}, 32'd1);
    check("end_din", {24'h0, ioctl_din}, {24'h0, mem[20]});
    check("end_raddr", {22'h0, ram_addr}, 32'd20);
    check("end_busy", {31'h0, busy}, 32'h0);
    check("end_pause_off", {31'h0, pause_cpu}, 32'h0);

    // Wrong index: strobes ignored
    ioctl_upload = 1'b1; ioctl_index = 8'd0; tick();
    prev = ioctl_din;
    issue_rd(25'd3, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("idx0_rreq%0d", i), {31'h0, ram_req}, 32'h0);
      tick();
    end
    check("idx0_din", {24'h0, ioctl_din}, {24'h0, prev});
    check("idx0_busy", {31'h0, busy}, 32'h0);
    ioctl_index = 8'd4;

    // Counter saturates at SIZE
    restart_session();
    for (int i = 0; i < 1030; i++) begin
      ioctl_rd = 1'b1; ioctl_addr = 25'd2048;
      if (i < 1024) sb.push_back(8'hFF);
      tick();
    end
    ioctl_rd = 1'b0;
    tick();
    check("sat_cnt", {21'h0, byte_count}, 32'd1024);
    check("sb_empty", sb.size(), 32'd0);

    // Reset while in REQ abandons the access
    ram_gnt = 1'b0;
    issue_rd(25'd30, 1'b0, 8'h00);
    check("rr_rreq", {31'h0, ram_req}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rr_din",  {24'h0, ioctl_din}, 32'h0);
    check("rr_rreq0",{31'h0, ram_req}, 32'h0);
    check("rr_raddr",{22'h0, ram_addr}, 32'h0);
    check("rr_busy", {31'h0, busy}, 32'h0);
    check("rr_cnt",  {21'h0, byte_count}, 32'h0);
    check("rr_pause",{31'h0, pause_cpu}, 32'h0);
    check("rr_ureq", {31'h0, ioctl_upload_req}, 32'h0);
    tick();
    reset = 1'b0;
    ram_gnt = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("rr_din_after", {24'h0, ioctl_din}, 32'h0);
    check("rr_cnt_after", {21'h0, byte_count}, 32'h0);
    check("rr_busy_after", {31'h0, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ioctl_upload_server.md
IOCTL_UPLOAD_SERVER -- requirements
Module: ioctl_upload_server

Interface
REQ-001 Parameter SIZE, default 1024: bytes of save RAM exposed to the HPS upload.
REQ-002 Parameter ADDR_W, default 10: RAM address width; 2**ADDR_W SHALL be >= SIZE.
REQ-003 Parameter UPLOAD_INDEX, default 8'd4: ioctl_index value this block serves.
REQ-004 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 save_req  in  1  one-cycle pulse: request an HPS save (upload) of the RAM.
REQ-007 ioctl_upload  in  1  high while HPS upload session active.
REQ-008 ioctl_index  in  8  upload target index.
REQ-009 ioctl_rd  in  1  one-cycle read strobe from HPS.
REQ-010 ioctl_addr  in  25  byte address qualified by ioctl_rd.
REQ-011 ioctl_din  out  8  byte returned to HPS.
REQ-012 ioctl_upload_req  out  1  level request to HPS to start an upload.
REQ-013 pause_cpu  out  1  holds the game CPU off the save RAM during a session.
REQ-014 ram_req  out  1  RAM read request; ram_addr  out  ADDR_W  RAM address.
REQ-015 ram_gnt  in  1  arbiter grant; ram_q  in  8  RAM data, valid exactly 1 cycle after the grant cycle.
REQ-016 busy  out  1  high when FSM not IDLE; byte_count  out  ADDR_W+1  bytes served this session.

Function
REQ-017 Session = ioctl_upload high AND ioctl_index == UPLOAD_INDEX; rd strobes outside a session SHALL be ignored.
REQ-018 FSM states IDLE, REQ, DATA; IDLE->REQ on accepted in-range rd; REQ->DATA in the cycle ram_gnt is high; DATA->IDLE next cycle.
REQ-019 In REQ, ram_req SHALL be high and ram_addr = captured ioctl_addr[ADDR_W-1:0]; ram_req low in every other state.
REQ-020 In DATA, ioctl_din SHALL load ram_q; latency rd->ioctl_din update = 3 cycles when ram_gnt is already high.
REQ-021 Out-of-range rd (ioctl_addr >= SIZE) SHALL load ioctl_din = 8'hFF in the next cycle without a RAM access; FSM stays IDLE.
REQ-022 ioctl_din SHALL hold its value until the next served byte.
REQ-023 rd arriving while FSM not IDLE SHALL be stored in a one-entry pending register (address captured) and served immediately on return to IDLE; a further rd while pending is full overwrites the pending address.
REQ-024 byte_count SHALL clear on session start (rising edge of session) and increment by 1 on each ioctl_din load, saturating at SIZE.
REQ-025 save_req SHALL set ioctl_upload_req; it clears on session rising edge; save_req while already set has no effect; save_req during a session is ignored.
REQ-026 pause_cpu SHALL rise the cycle after session start and fall one cycle after the session ends AND the FSM is IDLE with no pending rd.
REQ-027 Session ending mid-access: the outstanding RAM cycle SHALL complete and update ioctl_din; the pending entry SHALL be discarded.
REQ-028 ram_gnt low indefinitely: FSM SHALL remain in REQ with ram_req high; no timeout.

Reset
REQ-029 On reset: FSM IDLE, ioctl_din 8'h00, ioctl_upload_req 0, pause_cpu 0, ram_req 0, ram_addr 0, busy 0, byte_count 0, pending empty.
REQ-030 Reset asserted mid-access SHALL abandon the access immediately; no ioctl_din update afterwards.

Structure
REQ-031 FSM state enum and the 8'hFF fill constant SHALL live in the shared core package.
REQ-032 No sub-modules; single module, one FSM plus pending register and counters.

Verification
REQ-033 save_req pulse, then session with index 4 -> ioctl_upload_req high until session edge, pause_cpu high 1 cycle after edge.
REQ-034 RAM[0x005]=8'hA5, ram_gnt tied high, rd addr 5 -> ram_addr 5 in REQ, ioctl_din = 8'hA5 3 cycles after rd, byte_count 1.
REQ-035 rd addr 1024 (SIZE default) -> ioctl_din = 8'hFF next cycle, ram_req never asserted.
REQ-036 ram_gnt withheld 10 cycles, second rd addr 7 during wait -> both bytes served in order, byte_count 2.
REQ-037 rd with ioctl_index 0 -> no ram_req, ioctl_din unchanged; reset asserted in REQ -> all outputs at reset values next edge.
